// File: rtl/noc_local_bridge_pkg.sv
// noc_local_bridge_pkg: shared widths, flit layout and framing states for the local-port bridge.
`timescale 1ns/1ps
package noc_local_bridge_pkg;
   localparam int Noc_Data_Width = 32;
   localparam int CNT_W = 16;
   typedef struct packed {
      logic                      hdr;
      logic                      tail;
      logic [Noc_Data_Width-1:0] payload;
   } flit_t;
   typedef enum logic {IDLE, IN_PKT} bridge_state_e;
endpackage

// File: rtl/noc_local_bridge_fifo.sv
// noc_bridge_fifo: synchronous FIFO with extra-MSB pointers for full/empty detection.
`timescale 1ns/1ps
module noc_bridge_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wp_q, rp_q;
   logic         do_push, do_pop;
   assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign empty   = wp_q == rp_q;
   assign dout    = mem_q[rp_q[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_q + (AW+1)'(do_push);
         rp_q <= rp_q + (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/noc_local_bridge.sv
// noc_local_bridge: local-port bridge with per-channel injection FIFOs and framing checks,
// a 2-entry ejection skid buffer, sticky framing errors and packet counters.
`timescale 1ns/1ps
module noc_local_bridge
   import noc_local_bridge_pkg::*;
#(
   parameter int Data_Width  = Noc_Data_Width,
   parameter int Channel_Num = 2,
   parameter int Fifo_Depth  = 4,
   parameter int Max_Pkt_Len = 16
) (
   input  logic                                noc_clk,
   input  logic                                noc_rst_n,
   input  logic [Channel_Num-1:0]              in_valid,
   output logic [Channel_Num-1:0]              in_ready,
   input  logic [Channel_Num*Data_Width-1:0]   in_flit,
   input  logic [Channel_Num-1:0]              in_is_header,
   input  logic [Channel_Num-1:0]              in_is_tail,
   output logic [Channel_Num-1:0]              in_vc_ready,
   output logic [Channel_Num-1:0]              fab_in_valid,
   input  logic [Channel_Num-1:0]              fab_in_ready,
   output logic [Channel_Num*(Data_Width+2)-1:0] fab_in_flit,
   input  logic [Channel_Num-1:0]              fab_in_vc_ready,
   input  logic                                fab_out_valid,
   output logic                                fab_out_ready,
   input  logic [Data_Width+1:0]               fab_out_flit,
   output logic                                fab_out_vc_ready,
   output logic                                out_valid,
   input  logic                                out_ready,
   input  logic                                out_vc_ready,
   output logic [Data_Width-1:0]               out_flit,
   output logic                                out_is_header,
   output logic                                out_is_tail,
   input  logic                                err_clr,
   output logic [Channel_Num-1:0]              frame_err,
   output logic [Channel_Num*CNT_W-1:0]        tx_pkt_cnt,
   output logic [CNT_W-1:0]                    rx_pkt_cnt
);
   localparam int FW = Data_Width + 2;
   localparam int LW = $clog2(Max_Pkt_Len + 1);
   assign in_vc_ready      = fab_in_vc_ready;
   assign fab_out_vc_ready = out_vc_ready;
   for (genvar c = 0; c < Channel_Num; c++) begin : g_ch
      bridge_state_e st_q, st_d;
      logic [LW-1:0] len_q, len_d;
      logic [CNT_W-1:0] tx_q;
      logic          err_q, acc, hdr, tl, wr, force_tl, err_set, full, empty, pop;
      logic [FW-1:0] dout;
      assign hdr = in_is_header[c];
      assign tl  = in_is_tail[c];
      assign acc = in_valid[c] && in_ready[c];
      assign pop = fab_in_valid[c] && fab_in_ready[c];
      always_comb begin
         st_d     = st_q;
         len_d    = len_q;
         wr       = 1'b0;
         force_tl = 1'b0;
         err_set  = 1'b0;
         if (acc) begin
            if (st_q == IDLE) begin
               wr      = hdr;
               err_set = !hdr;
               if (hdr && !tl) begin
                  st_d  = IN_PKT;
                  len_d = LW'(1);
               end
            end else if (hdr) begin
               err_set = 1'b1;
            end else begin
               wr = 1'b1;
               if (tl) st_d = IDLE;
               // Truncate an overlong packet so the fabric always sees a tail.
               else if (len_q == LW'(Max_Pkt_Len - 1)) begin
                  force_tl = 1'b1;
                  err_set  = 1'b1;
                  st_d     = IDLE;
               end else len_d = len_q + LW'(1);
            end
         end
      end
      noc_bridge_fifo #(.W(FW), .DEPTH(Fifo_Depth)) u_fifo (
         .clk   (noc_clk),
         .rst_n (noc_rst_n),
         .push  (wr),
         .din   ({hdr, tl | force_tl, in_flit[c*Data_Width +: Data_Width]}),
         .pop   (pop),
         .dout  (dout),
         .full  (full),
         .empty (empty)
      );
      always_ff @(posedge noc_clk or negedge noc_rst_n) begin
         if (!noc_rst_n) begin
            st_q  <= IDLE;
            len_q <= '0;
            err_q <= 1'b0;
            tx_q  <= '0;
         end else begin
            st_q  <= st_d;
            len_q <= len_d;
            err_q <= err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
            tx_q  <= tx_q + CNT_W'(pop && dout[FW-2]);
         end
      end
      assign in_ready[c]                = !full;
      assign fab_in_valid[c]            = !empty;
      assign fab_in_flit[c*FW +: FW]    = dout;
      assign frame_err[c]               = err_q;
      assign tx_pkt_cnt[c*CNT_W +: CNT_W] = tx_q;
   end
   logic [FW-1:0]    sk_q [2];
   logic             sk_wp_q, sk_rp_q, fab_out_rdy_q, sk_push, sk_pop;
   logic [1:0]       sk_cnt_q, sk_cnt_d;
   logic [CNT_W-1:0] rx_q;
   assign sk_push       = fab_out_valid && fab_out_rdy_q;
   assign sk_pop        = out_valid && out_ready;
   assign sk_cnt_d      = sk_cnt_q + {1'b0, sk_push} - {1'b0, sk_pop};
   assign out_valid     = sk_cnt_q != 2'd0;
   assign {out_is_header, out_is_tail, out_flit} = sk_q[sk_rp_q];
   assign fab_out_ready = fab_out_rdy_q;
   assign rx_pkt_cnt    = rx_q;
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         sk_cnt_q      <= '0;
         sk_wp_q       <= 1'b0;
         sk_rp_q       <= 1'b0;
         fab_out_rdy_q <= 1'b1;
         rx_q          <= '0;
      end else begin
         sk_cnt_q      <= sk_cnt_d;
         sk_wp_q       <= sk_wp_q ^ sk_push;
         sk_rp_q       <= sk_rp_q ^ sk_pop;
         fab_out_rdy_q <= sk_cnt_d != 2'd2;
         rx_q          <= rx_q + CNT_W'(sk_pop && out_is_tail);
      end
   end
   always_ff @(posedge noc_clk) begin
      if (sk_push) sk_q[sk_wp_q] <= fab_out_flit;
   end
endmodule

// File: tb/tb_noc_local_bridge.sv
// tb_noc_local_bridge: directed checks of injection framing, buffering, ejection and reset.
`timescale 1ns/1ps
module tb_noc_local_bridge;
   localparam int DW = 8, CN = 2, FW = DW + 2;
   logic            clk = 1'b0, rst_n = 1'b0;
   logic [CN-1:0]   in_valid = '0, in_is_header = '0, in_is_tail = '0;
   logic [CN-1:0]   in_ready, in_vc_ready, fab_in_valid, frame_err;
   logic [CN-1:0]   fab_in_ready = '1, fab_in_vc_ready = '0;
   logic [CN*DW-1:0] in_flit = '0;
   logic [CN*FW-1:0] fab_in_flit;
   logic            fab_out_valid = 1'b0, out_ready = 1'b0, out_vc_ready = 1'b0, err_clr = 1'b0;
   logic [FW-1:0]   fab_out_flit = '0;
   logic            fab_out_ready, fab_out_vc_ready, out_valid, out_is_header, out_is_tail;
   logic [DW-1:0]   out_flit;
   logic [CN*16-1:0] tx_pkt_cnt;
   logic [15:0]     rx_pkt_cnt;
   int checks = 0, errors = 0;

   noc_local_bridge #(.Data_Width(DW), .Channel_Num(CN), .Fifo_Depth(4), .Max_Pkt_Len(4)) dut (
      .noc_clk(clk), .noc_rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
      .in_is_header(in_is_header), .in_is_tail(in_is_tail), .in_vc_ready(in_vc_ready),
      .fab_in_valid(fab_in_valid), .fab_in_ready(fab_in_ready), .fab_in_flit(fab_in_flit),
      .fab_in_vc_ready(fab_in_vc_ready),
      .fab_out_valid(fab_out_valid), .fab_out_ready(fab_out_ready), .fab_out_flit(fab_out_flit),
      .fab_out_vc_ready(fab_out_vc_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_vc_ready(out_vc_ready),
      .out_flit(out_flit), .out_is_header(out_is_header), .out_is_tail(out_is_tail),
      .err_clr(err_clr), .frame_err(frame_err), .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drv(input int c, input logic v, input logic h, input logic t, input logic [DW-1:0] d);
      in_valid[c]            = v;
      in_is_header[c]        = h;
      in_is_tail[c]          = t;
      in_flit[c*DW +: DW]    = d;
   endtask

   initial begin
      bit acc;
      int got, cyc, g;
      step(2);
      chk("rst_fab_in_valid", 32'(fab_in_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 3);
      chk("rst_fab_out_ready", 32'(fab_out_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      chk("rst_tx_cnt", tx_pkt_cnt, 0);
      chk("rst_rx_cnt", 32'(rx_pkt_cnt), 0);
      rst_n = 1'b1;
      step;
      fab_in_vc_ready = 2'b10;
      out_vc_ready    = 1'b1;
      #1;
      chk("in_vc_ready", 32'(in_vc_ready), 2);
      chk("fab_out_vc_ready", 32'(fab_out_vc_ready), 1);
      // 3-flit packet on channel 0
      drv(0, 1, 1, 0, 8'hA1); step;
      chk("p1_h_valid", 32'(fab_in_valid[0]), 1);
      chk("p1_h_flit", 32'(fab_in_flit[0 +: FW]), 32'h2A1);
      drv(0, 1, 0, 0, 8'hA2); step;
      chk("p1_b_flit", 32'(fab_in_flit[0 +: FW]), 32'h0A2);
      drv(0, 1, 0, 1, 8'hA3); step;
      chk("p1_t_flit", 32'(fab_in_flit[0 +: FW]), 32'h1A3);
      drv(0, 0, 0, 0, 8'h00); step;
      chk("p1_idle", 32'(fab_in_valid[0]), 0);
      chk("p1_tx_cnt0", 32'(tx_pkt_cnt[15:0]), 1);
      chk("p1_frame_err", 32'(frame_err), 0);
      // channel 1 backpressure: 5 single-flit packets into a 4-deep FIFO
      fab_in_ready[1] = 1'b0;
      drv(1, 1, 1, 1, 8'h10);
      for (int k = 1; k <= 4; k++) begin
         step;
         chk("bp_in_ready", 32'(in_ready[1]), (k < 4) ? 1 : 0);
         drv(1, 1, 1, 1, 8'(8'h10 + k));
      end
      step;
      chk("bp_full_hold", 32'(in_ready[1]), 0);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", 32'(fab_in_valid[1]), 1);
         chk("bp_order", 32'(fab_in_flit[FW +: FW]), 32'h310 + k);
         if (k == 0) fab_in_ready[1] = 1'b1;
         if (k == 1) chk("bp_ready_after_pop", 32'(in_ready[1]), 1);
         if (k == 2) drv(1, 0, 0, 0, 8'h00);
         step;
      end
      chk("bp_drained", 32'(fab_in_valid[1]), 0);
      chk("bp_tx_cnt1", 32'(tx_pkt_cnt[31:16]), 5);
      // framing errors on channel 0
      drv(0, 1, 0, 0, 8'hB0); step;
      drv(0, 0, 0, 0, 8'h00);
      chk("fe_idle_body_drop", 32'(fab_in_valid[0]), 0);
      chk("fe_idle_body_err", 32'(frame_err[0]), 1);
      err_clr = 1'b1; step; err_clr = 1'b0;
      chk("fe_clr", 32'(frame_err[0]), 0);
      drv(0, 1, 1, 0, 8'hC0); step;
      chk("fe_hdr_ok", 32'(fab_in_flit[0 +: FW]), 32'h2C0);
      drv(0, 1, 1, 0, 8'hC1); step;
      drv(0, 0, 0, 0, 8'h00);
      chk("fe_hdr_in_pkt_drop", 32'(fab_in_valid[0]), 0);
      chk("fe_hdr_in_pkt_err", 32'(frame_err[0]), 1);
      err_clr = 1'b1; drv(0, 1, 1, 0, 8'hC2); step;
      drv(0, 0, 0, 0, 8'h00);
      chk("fe_set_beats_clr", 32'(frame_err[0]), 1);
      step;
      err_clr = 1'b0;
      chk("fe_clr2", 32'(frame_err[0]), 0);
      drv(0, 1, 0, 1, 8'hC3); step;
      drv(0, 0, 0, 0, 8'h00);
      chk("fe_tail_after_drops", 32'(fab_in_flit[0 +: FW]), 32'h1C3);
      step;
      chk("fe_tx_cnt0", 32'(tx_pkt_cnt[15:0]), 2);
      // overlong packet: header + 5 body flits, Max_Pkt_Len=4
      drv(0, 1, 1, 0, 8'hD0); step;
      chk("ml_h", 32'(fab_in_flit[0 +: FW]), 32'h2D0);
      drv(0, 1, 0, 0, 8'hD1); step;
      chk("ml_b1", 32'(fab_in_flit[0 +: FW]), 32'h0D1);
      drv(0, 1, 0, 0, 8'hD2); step;
      chk("ml_b2", 32'(fab_in_flit[0 +: FW]), 32'h0D2);
      chk("ml_no_err_yet", 32'(frame_err[0]), 0);
      drv(0, 1, 0, 0, 8'hD3); step;
      chk("ml_forced_tail", 32'(fab_in_flit[0 +: FW]), 32'h1D3);
      chk("ml_err", 32'(frame_err[0]), 1);
      drv(0, 1, 0, 0, 8'hD4); step;
      chk("ml_drop_b4", 32'(fab_in_valid[0]), 0);
      drv(0, 1, 0, 0, 8'hD5); step;
      drv(0, 0, 0, 0, 8'h00);
      chk("ml_drop_b5", 32'(fab_in_valid[0]), 0);
      chk("ml_tx_cnt0", 32'(tx_pkt_cnt[15:0]), 3);
      // ejection: 100 single-flit packets with random out_ready
      got = 0;
      cyc = 0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               fab_out_valid = 1'b1;
               fab_out_flit  = {2'b11, 8'(i)};
               g = 0;
               do begin
                  acc = fab_out_ready;
                  step;
                  g++;
               end while (!acc && g < 1000);
            end
            fab_out_valid = 1'b0;
         end
         begin
            while (got < 100 && cyc < 5000) begin
               out_ready = 1'($urandom_range(0, 1));
               if (out_valid && out_ready) begin
                  chk("ej_data", 32'({out_is_header, out_is_tail, out_flit}), 32'({2'b11, 8'(got)}));
                  got++;
               end
               step;
               cyc++;
            end
         end
      join
      chk("ej_count", 32'(got), 100);
      out_ready = 1'b1;
      step(3);
      chk("ej_no_extra", 32'(out_valid), 0);
      chk("ej_rx_cnt", 32'(rx_pkt_cnt), 100);
      // reset in the middle of a buffered packet
      fab_in_ready[0] = 1'b0;
      drv(0, 1, 1, 0, 8'hE0); step;
      drv(0, 1, 0, 0, 8'hE1); step;
      drv(0, 1, 0, 0, 8'hE2); step;
      drv(0, 0, 0, 0, 8'h00);
      chk("mr_holding", 32'(fab_in_valid[0]), 1);
      rst_n = 1'b0;
      #1;
      chk("mr_valid_cleared", 32'(fab_in_valid), 0);
      chk("mr_tx_cleared", tx_pkt_cnt, 0);
      chk("mr_rx_cleared", 32'(rx_pkt_cnt), 0);
      chk("mr_err_cleared", 32'(frame_err), 0);
      step;
      rst_n = 1'b1;
      fab_in_ready = '1;
      step;
      drv(0, 1, 1, 0, 8'hF0); step;
      chk("mr_new_h", 32'(fab_in_flit[0 +: FW]), 32'h2F0);
      drv(0, 1, 0, 1, 8'hF1); step;
      drv(0, 0, 0, 0, 8'h00);
      chk("mr_new_t", 32'(fab_in_flit[0 +: FW]), 32'h1F1);
      step;
      chk("mr_new_tx", 32'(tx_pkt_cnt[15:0]), 1);
      chk("mr_new_err", 32'(frame_err), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
